key_conditioner: RTL

- Front-end conditioner for the stopwatch pushbuttons. It sits directly upstream of the stopwatch control FSM.
- Takes raw, asynchronous, bouncing board keys (active-low) and produces per key:
  - clean, synchronous single-cycle press and release pulses,
  - a debounced level,
  - a long-press pulse.
- The stopwatch consumes these outputs as its start, stop and reset requests.

---
 rtl/key_conditioner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: pushbutton front end for the stopwatch control FSM.
// Each active-low board key is synchronized, debounced and turned into
// registered press / release / long-press pulses plus a debounced level.
// The release pulse output is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 100000000
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] level,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_press
);

  // Counter widths; a 1-cycle debounce still needs a 1-bit counter.
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_s;

  // Two-stage synchronizer; idles at 1 so a reset looks like "released".
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t        r_state;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    logic          r_lp_done;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;

    // Per-key debounce / hold FSM with registered level and pulses.
    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        r_state   <= IDLE;
        r_dcnt    <= '0;
        r_hcnt    <= '0;
        r_lp_done <= 1'b0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        case (r_state)
          IDLE: begin
            if (w_s[k]) begin
              r_state <= PRESS_WAIT;
              r_dcnt  <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!w_s[k]) begin
              r_state <= IDLE;
            end else if (r_dcnt == D_LAST) begin
              r_state   <= HELD;
              r_press   <= 1'b1;
              r_level   <= 1'b1;
              r_hcnt    <= '0;
              r_lp_done <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          HELD: begin
            if (!w_s[k]) begin
              r_state <= RELEASE_WAIT;
              r_dcnt  <= '0;
            end else if (r_hcnt == H_LAST) begin
              if (!r_lp_done) begin
                r_long    <= 1'b1;
                r_lp_done <= 1'b1;
              end
            end else begin
              r_hcnt <= r_hcnt + HW'(1);
            end
          end
          RELEASE_WAIT: begin
            // A release glitch returns to HELD without losing hold progress.
            if (w_s[k]) begin
              r_state <= HELD;
            end else if (r_dcnt == D_LAST) begin
              r_state   <= IDLE;
              r_release <= 1'b1;
              r_level   <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end

    assign level[k]         = r_level;
    assign press[k]         = r_press;
    assign release_pulse[k] = r_release;
    assign long_press[k]    = r_long;
  end

endmodule
